// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency 16-bit word memory answering one request at a time with stall/done handshaking.
// Define MEM_ALIGN_CHECK_EN to reject odd byte addresses with err instead of accessing memory.
module data_mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        done,
  output logic        stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} stateT;
  stateT state, nextState;
  logic [3:0] count;
  logic [DEPTH_LOG2-1:0] latIdx, accIdx;
  logic [15:0] latData, accData;
  logic latWr, accWr, accept, enterDone, memOk;
  logic [15:0] mem [2**DEPTH_LOG2];
  logic unusedBits;
  assign unusedBits = ^{addr[15:DEPTH_LOG2+1], addr[0]};
  assign accept = state == IDLE && enable;
  // With LATENCY=1 the access edge is the accept edge, so the live inputs are used directly.
  assign accIdx = accept ? addr[DEPTH_LOG2:1] : latIdx;
  assign accData = accept ? data_in : latData;
  assign accWr = accept ? wr : latWr;
  assign enterDone = nextState == DONE && state != DONE;
  assign done = state == DONE;
  assign stall = rst && (accept || state == WAIT);
  always_comb begin
    nextState = state == IDLE ? (enable ? (LATENCY == 1 ? DONE : WAIT) : IDLE) :
                state == WAIT ? (count == 4'd1 ? DONE : WAIT) : IDLE;
  end
`ifdef MEM_ALIGN_CHECK_EN
  logic latOdd;
  assign memOk = !(accept ? addr[0] : latOdd);
  assign err = state == DONE && latOdd;
  always_ff @(posedge clk or negedge rst)
    if (!rst) latOdd <= 1'b0;
    else if (accept) latOdd <= addr[0];
`else
  assign memOk = 1'b1;
  assign err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      latIdx <= '0;
      latData <= '0;
      latWr <= 1'b0;
    end else begin
      state <= nextState;
      count <= accept ? 4'(LATENCY - 1) : state == WAIT ? count - 4'd1 : count;
      if (accept) begin
        latIdx <= addr[DEPTH_LOG2:1];
        latData <= data_in;
        latWr <= wr;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
      data_out <= '0;
    end else if (enterDone && memOk) begin
      if (accWr) mem[accIdx] <= accData;
      else data_out <= mem[accIdx];
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed requests with a done-triggered scoreboard monitor.
module tb_data_mem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b0, enable = 1'b1, wr = 1'b0, done, stall, err;
  logic [15:0] addr = '0, data_in = '0, data_out;
  int cyc = 0, checks = 0, errors = 0;
  typedef struct { int cyc; logic [15:0] data; logic err; } expT;
  expT q[$];

  data_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .done(done), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic errExp(input logic [15:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return a[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp,
                     input logic chg = 1'b0, input logic [15:0] a2 = '0, input logic [15:0] d2 = '0);
    @(negedge clk);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    q.push_back('{cyc + LAT, exp, errExp(a)});
    #1 chk("stall_accept", 16'(stall), 16'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        enable = 1'b0;
        if (chg) begin addr = a2; data_in = d2; end
      end
      #1 chk("stall_busy", 16'(stall), 16'(k < LAT));
      chk("done_timing", 16'(done), 16'(k == LAT));
    end
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      expT e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cyc=%0d data_out=%h", cyc, data_out);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || data_out !== e.data || err !== e.err) begin
          errors++;
          $display("FAIL response cyc got %0d want %0d data_out got %h want %h err got %b want %b",
                   cyc, e.cyc, data_out, e.data, err, e.err);
        end
      end
    end
  end

  initial begin
    int c;
    #12;
    chk("reset_stall", 16'(stall), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_err", 16'(err), 16'd0);
    chk("reset_data_out", data_out, 16'h0000);
    @(negedge clk);
    enable = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1 chk("idle_stall", 16'(stall), 16'd0);
    req(1'b1, 16'h0004, 16'h1234, 16'h0000);
    req(1'b0, 16'h0004, 16'h0000, 16'h1234);
    req(1'b1, 16'h0010, 16'hBEEF, 16'h1234, 1'b1, 16'h0020, 16'h0000);
    req(1'b0, 16'h0010, 16'h0000, 16'hBEEF);
    req(1'b0, 16'h0020, 16'h0000, 16'h0000);
    req(1'b1, 16'h0202, 16'h5A5A, 16'h0000);
    req(1'b0, 16'h0002, 16'h0000, 16'h5A5A);
    req(1'b0, 16'h0004, 16'h0000, 16'h1234);
    req(1'b1, 16'h0002, 16'h7777, 16'h1234);
`ifdef MEM_ALIGN_CHECK_EN
    req(1'b0, 16'h0003, 16'h0000, 16'h1234);
`else
    req(1'b0, 16'h0003, 16'h0000, 16'h7777);
`endif
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = 16'h0010; c = cyc;
    for (int i = 0; i < 3; i++) q.push_back('{c + LAT + (LAT + 1) * i, 16'hBEEF, 1'b0});
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      if (k > 0) @(negedge clk);
      #1 chk("held_done", 16'(done), 16'(k % (LAT + 1) == LAT));
      chk("held_stall", 16'(stall), 16'(k % (LAT + 1) != LAT));
    end
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1; wr = 1'b1; addr = 16'h0008; data_in = 16'hFFFF;
    @(negedge clk);
    enable = 1'b0;
    #1 rst = 1'b0;
    #1 chk("abort_stall", 16'(stall), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_data_out", data_out, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    req(1'b0, 16'h0008, 16'h0000, 16'h0000);
    req(1'b0, 16'h0010, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_done got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
